// File: rtl/if_fetch_stage_pkg.sv
// rtl/if_fetch_stage_pkg.sv - shared widths, bubble encoding and fetch FSM states
package if_fetch_stage_pkg;

  localparam int WORD_SIZE = 16;

  // Undefined R-type func: the ID-stage decoder produces no control activity for it.
  localparam logic [15:0] BUBBLE_INST = 16'hF03F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - instruction-memory read handshake bundle
interface if_fetch_stage_if #(
  parameter int WORD_SIZE = if_fetch_stage_pkg::WORD_SIZE
);

  logic                 i_mem_read;
  logic [WORD_SIZE-1:0] i_address;
  logic [WORD_SIZE-1:0] i_data;
  logic                 i_ready;

  modport master (output i_mem_read, output i_address, input i_data, input i_ready);
  modport slave  (input i_mem_read, input i_address, output i_data, output i_ready);

endinterface

// File: rtl/if_fetch_stage_skid.sv
// rtl/if_fetch_stage_skid.sv - one-entry inst/pc_next holding register for ID stalls
module fetch_skid_buffer #(
  parameter int WORD_SIZE = if_fetch_stage_pkg::WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_load,
  input  logic                 i_unload,
  input  logic                 i_clear,
  input  logic [WORD_SIZE-1:0] i_inst,
  input  logic [WORD_SIZE-1:0] i_pc_next,
  output logic                 o_valid,
  output logic [WORD_SIZE-1:0] o_inst,
  output logic [WORD_SIZE-1:0] o_pc_next
);

  logic                 r_valid;
  logic [WORD_SIZE-1:0] r_inst;
  logic [WORD_SIZE-1:0] r_pc_next;

  // Load wins over unload so a simultaneous unload+refill keeps the entry occupied.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid   <= 1'b0;
      r_inst    <= '0;
      r_pc_next <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid   <= 1'b1;
      r_inst    <= i_inst;
      r_pc_next <= i_pc_next;
    end else if (i_unload) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid   = r_valid;
  assign o_inst    = r_inst;
  assign o_pc_next = r_pc_next;

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - PC, instruction-memory request FSM and IF/ID register
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int                   WORD_SIZE = if_fetch_stage_pkg::WORD_SIZE,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  if_fetch_stage_if.master     imem,
  input  logic                 id_stall,
  input  logic                 redirect_valid,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  input  logic                 halt,
  output logic [WORD_SIZE-1:0] if_id_inst,
  output logic [WORD_SIZE-1:0] if_id_pc_next,
  output logic                 if_id_valid,
  output logic [WORD_SIZE-1:0] fetch_count
);

  localparam logic [WORD_SIZE-1:0] W_BUBBLE = WORD_SIZE'(BUBBLE_INST);

  fetch_state_e         r_state, w_nxt_state;
  logic [WORD_SIZE-1:0] r_pc, w_pc_nxt, w_pc_inc;
  logic [WORD_SIZE-1:0] r_addr, w_addr_nxt;
  logic                 r_mem_read;
  logic                 r_halt_pend, w_halt_pend_nxt;

  logic [WORD_SIZE-1:0] r_inst, r_pc_next, r_count;
  logic                 r_valid;
  logic                 w_ifid_load, w_ifid_bubble;
  logic [WORD_SIZE-1:0] w_ifid_inst, w_ifid_pc_next;

  logic                 w_skid_load, w_skid_unload, w_skid_clear, w_skid_valid;
  logic [WORD_SIZE-1:0] w_skid_inst, w_skid_pc_next;

  assign w_pc_inc = r_pc + WORD_SIZE'(1);

  fetch_skid_buffer #(.WORD_SIZE(WORD_SIZE)) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_load    (w_skid_load),
    .i_unload  (w_skid_unload),
    .i_clear   (w_skid_clear),
    .i_inst    (imem.i_data),
    .i_pc_next (w_pc_inc),
    .o_valid   (w_skid_valid),
    .o_inst    (w_skid_inst),
    .o_pc_next (w_skid_pc_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state     = r_state;
    w_pc_nxt        = r_pc;
    w_addr_nxt      = r_addr;
    w_halt_pend_nxt = r_halt_pend;
    w_skid_load     = 1'b0;
    w_skid_unload   = 1'b0;
    w_skid_clear    = 1'b0;
    w_ifid_load     = 1'b0;
    w_ifid_bubble   = 1'b0;
    w_ifid_inst     = imem.i_data;
    w_ifid_pc_next  = w_pc_inc;
    case (r_state)
      ST_IDLE: begin
        if (halt) begin
          w_skid_clear  = 1'b1;
          w_ifid_bubble = 1'b1;
          w_nxt_state   = ST_HALTED;
        end else if (redirect_valid) begin
          w_skid_clear  = 1'b1;
          w_ifid_bubble = 1'b1;
          w_pc_nxt      = redirect_pc;
          w_addr_nxt    = redirect_pc;
          w_nxt_state   = ST_REQ;
        end else begin
          if (!id_stall) begin
            if (w_skid_valid) begin
              w_skid_unload  = 1'b1;
              w_ifid_load    = 1'b1;
              w_ifid_inst    = w_skid_inst;
              w_ifid_pc_next = w_skid_pc_next;
            end else begin
              w_ifid_bubble = 1'b1;
            end
          end
          // Resume fetching only once the buffered word has somewhere to go.
          if (!id_stall || !w_skid_valid) begin
            w_addr_nxt  = r_pc;
            w_nxt_state = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (halt) begin
          w_skid_clear  = 1'b1;
          w_ifid_bubble = 1'b1;
          if (imem.i_ready) begin
            w_nxt_state = ST_HALTED;
          end else begin
            w_halt_pend_nxt = 1'b1;
            w_nxt_state     = ST_DRAIN;
          end
        end else if (redirect_valid) begin
          w_skid_clear  = 1'b1;
          w_ifid_bubble = 1'b1;
          w_pc_nxt      = redirect_pc;
          if (imem.i_ready) w_addr_nxt  = redirect_pc;
          else              w_nxt_state = ST_DRAIN;
        end else begin
          if (!id_stall) begin
            if (w_skid_valid) begin
              w_skid_unload  = 1'b1;
              w_ifid_load    = 1'b1;
              w_ifid_inst    = w_skid_inst;
              w_ifid_pc_next = w_skid_pc_next;
            end else if (imem.i_ready) begin
              w_ifid_load = 1'b1;
            end else begin
              w_ifid_bubble = 1'b1;
            end
          end
          if (imem.i_ready) begin
            w_pc_nxt   = w_pc_inc;
            w_addr_nxt = w_pc_inc;
            if (id_stall || w_skid_valid) begin
              w_skid_load = 1'b1;
              w_nxt_state = ST_IDLE;
            end
          end
        end
      end
      ST_DRAIN: begin
        // IF/ID was flushed on entry and nothing is delivered while draining.
        w_ifid_bubble = 1'b1;
        if (halt) w_halt_pend_nxt = 1'b1;
        else if (redirect_valid && !r_halt_pend) w_pc_nxt = redirect_pc;
        if (imem.i_ready) begin
          if (halt || r_halt_pend) begin
            w_halt_pend_nxt = 1'b0;
            w_nxt_state     = ST_HALTED;
          end else begin
            w_addr_nxt  = redirect_valid ? redirect_pc : r_pc;
            w_nxt_state = ST_REQ;
          end
        end
      end
      ST_HALTED: begin
        w_ifid_bubble = 1'b1;
      end
      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc        <= RESET_PC;
      r_addr      <= RESET_PC;
      r_mem_read  <= 1'b0;
      r_halt_pend <= 1'b0;
      r_inst      <= W_BUBBLE;
      r_pc_next   <= '0;
      r_valid     <= 1'b0;
      r_count     <= '0;
    end else begin
      r_pc        <= w_pc_nxt;
      r_addr      <= w_addr_nxt;
      r_mem_read  <= (w_nxt_state == ST_REQ) || (w_nxt_state == ST_DRAIN);
      r_halt_pend <= w_halt_pend_nxt;
      if (w_ifid_bubble) begin
        r_inst  <= W_BUBBLE;
        r_valid <= 1'b0;
      end else if (w_ifid_load) begin
        r_inst    <= w_ifid_inst;
        r_pc_next <= w_ifid_pc_next;
        r_valid   <= 1'b1;
        r_count   <= r_count + WORD_SIZE'(1);
      end
    end
  end

  assign imem.i_mem_read = r_mem_read;
  assign imem.i_address  = r_addr;
  assign if_id_inst      = r_inst;
  assign if_id_pc_next   = r_pc_next;
  assign if_id_valid     = r_valid;
  assign fetch_count     = r_count;

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - directed and randomized checks of if_fetch_stage against a fetch model
module tb_if_fetch_stage;
  import if_fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        id_stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        halt = 1'b0;
  logic [15:0] if_id_inst, if_id_pc_next, fetch_count;
  logic        if_id_valid;

  int checks = 0;
  int errors = 0;

  if_fetch_stage_if #(.WORD_SIZE(16)) mif ();

  if_fetch_stage #(.WORD_SIZE(16), .RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem           (mif),
    .id_stall       (id_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .if_id_inst     (if_id_inst),
    .if_id_pc_next  (if_id_pc_next),
    .if_id_valid    (if_id_valid),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  // Reference model: one outstanding request (address, discard/halt flags),
  // a FIFO of held words, and the IF/ID contents.
  bit          m_req, m_disc, m_hafter, m_halted, m_valid;
  logic [15:0] m_pc, m_addr, m_inst, m_pcn, m_count;
  logic [31:0] q_buf[$];

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'h6001 + a * 16'h0101;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_req = 0; m_disc = 0; m_hafter = 0; m_halted = 0; m_valid = 0;
    m_pc = 16'h0; m_addr = 16'h0; m_inst = BUBBLE_INST; m_pcn = 16'h0; m_count = 16'h0;
    q_buf.delete();
  endtask

  task automatic model_flush();
    m_valid = 0;
    m_inst  = BUBBLE_INST;
    q_buf.delete();
  endtask

  task automatic model_edge(input bit st, input bit rv, input logic [15:0] rp, input bit h, input bit rd);
    bit          got, deliv;
    logic [15:0] w;
    got = m_req && rd;
    if (m_halted) begin
      m_req = 0;
    end else if (h) begin
      model_flush();
      if (m_req && !rd) begin
        m_disc = 1; m_hafter = 1;
      end else begin
        m_req = 0; m_halted = 1; m_disc = 0; m_hafter = 0;
      end
    end else if (rv && !m_hafter) begin
      model_flush();
      m_pc = rp;
      if (m_req && !rd) m_disc = 1;
      else begin m_req = 1; m_addr = rp; m_disc = 0; end
    end else begin
      deliv = got && !m_disc;
      w = mem_word(m_addr);
      if (!st) begin
        if (q_buf.size() > 0) begin
          {m_inst, m_pcn} = q_buf.pop_front();
          m_valid = 1; m_count++;
          if (deliv) q_buf.push_back({w, 16'(m_addr + 16'd1)});
        end else if (deliv) begin
          m_inst = w; m_pcn = m_addr + 16'd1; m_valid = 1; m_count++;
        end else begin
          m_valid = 0; m_inst = BUBBLE_INST;
        end
      end else if (deliv) begin
        q_buf.push_back({w, 16'(m_addr + 16'd1)});
      end
      if (got) begin
        if (m_hafter) begin
          m_req = 0; m_halted = 1; m_hafter = 0; m_disc = 0;
        end else if (m_disc) begin
          m_disc = 0; m_addr = m_pc;
        end else begin
          m_pc = m_pc + 16'd1;
          if (q_buf.size() > 0) m_req = 0;
          else m_addr = m_pc;
        end
      end else if (!m_req && q_buf.size() == 0) begin
        m_req = 1; m_addr = m_pc;
      end
    end
  endtask

  task automatic check_model();
    chk("mem_read", mif.i_mem_read, m_req);
    if (m_req) chk("address", mif.i_address, m_addr);
    chk("valid", if_id_valid, m_valid);
    chk("inst", if_id_inst, m_inst);
    chk("pc_next", if_id_pc_next, m_pcn);
    chk("count", fetch_count, m_count);
  endtask

  task automatic check_reset_vals();
    chk("rst_mem_read", mif.i_mem_read, 1'b0);
    chk("rst_address", mif.i_address, 16'h0000);
    chk("rst_inst", if_id_inst, 16'hF03F);
    chk("rst_valid", if_id_valid, 1'b0);
    chk("rst_pc_next", if_id_pc_next, 16'h0000);
    chk("rst_count", fetch_count, 16'h0000);
  endtask

  // Inputs change at the falling edge; outputs are compared at the next falling edge.
  task automatic cyc(input bit st, input bit rv, input logic [15:0] rp, input bit h, input bit rd);
    id_stall = st; redirect_valid = rv; redirect_pc = rp; halt = h;
    mif.i_ready = rd;
    mif.i_data  = rd ? mem_word(mif.i_address) : 16'($urandom);
    @(posedge clk);
    model_edge(st, rv, rp, h, rd);
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals();
    model_reset();
    id_stall = 0; redirect_valid = 0; halt = 0; mif.i_ready = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  logic [15:0] held;

  initial begin
    mif.i_ready = 1'b0;
    mif.i_data  = 16'h0;
    model_reset();
    @(negedge clk);
    check_reset_vals();
    @(negedge clk);
    reset_n = 1'b1;

    cyc(0, 0, 0, 0, 0);
    chk("first_req", mif.i_mem_read, 1'b1);

    // Zero-wait stream
    cyc(0, 0, 0, 0, 1);
    chk("zw_inst0", if_id_inst, 16'h6001);
    chk("zw_pcn0", if_id_pc_next, 16'h0001);
    cyc(0, 0, 0, 0, 1);
    chk("zw_inst1", if_id_inst, 16'h6102);
    cyc(0, 0, 0, 0, 1);
    chk("zw_inst2", if_id_inst, 16'h6203);
    chk("zw_pcn2", if_id_pc_next, 16'h0003);
    chk("zw_count", fetch_count, 16'd3);

    // Two wait cycles per access
    for (int k = 0; k < 2; k++) begin
      cyc(0, 0, 0, 0, 0);
      chk("wait_addr", mif.i_address, 16'(16'd3 + k));
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1);
    end

    // Stall for three cycles with zero-wait memory
    cyc(0, 0, 0, 0, 1);
    held = m_inst;
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 0, 0, 1);
      chk("stall_hold", if_id_inst, held);
    end
    chk("stall_no_req", mif.i_mem_read, 1'b0);
    cyc(0, 0, 0, 0, 1);
    chk("skid_first", if_id_inst, mem_word(16'd6));
    cyc(0, 0, 0, 0, 1);
    chk("after_skid", if_id_inst, mem_word(16'd7));

    // Redirect while a request waits
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 16'h0040, 0, 0);
    chk("redir_flush_v", if_id_valid, 1'b0);
    chk("redir_flush_i", if_id_inst, 16'hF03F);
    cyc(0, 0, 0, 0, 1);
    chk("redir_addr", mif.i_address, 16'h0040);
    cyc(0, 0, 0, 0, 1);
    chk("redir_inst", if_id_inst, mem_word(16'h0040));

    // Redirect and stall together, then wrap at the top of the address space
    cyc(1, 1, 16'hFFFF, 0, 1);
    chk("rs_flush", if_id_valid, 1'b0);
    chk("rs_addr", mif.i_address, 16'hFFFF);
    cyc(0, 0, 0, 0, 1);
    chk("wrap_pcn", if_id_pc_next, 16'h0000);
    chk("wrap_addr", mif.i_address, 16'h0000);

    // Randomized epochs
    for (int e = 0; e < 4; e++) begin
      for (int n = 0; n < 200; n++) begin
        cyc(($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0), 16'($urandom),
            ($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 6));
      end
      do_reset();
    end

    // Halt during an outstanding request
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("halt_held_req", mif.i_mem_read, 1'b1);
    chk("halt_flush", if_id_valid, 1'b0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("halt_done", mif.i_mem_read, 1'b0);
    for (int k = 0; k < 6; k++) begin
      cyc(k[0], 1, 16'h0100, 0, 1);
      chk("halted_no_req", mif.i_mem_read, 1'b0);
    end
    chk("halted_count", fetch_count, 16'd1);

    // Asynchronous reset mid-run
    do_reset();
    for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0, 1);
    do_reset();
    cyc(0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the 16-bit pipelined CPU. It holds the PC and issues word-addressed instruction-memory reads over a ready handshake. It latches fetched words into the IF/ID register that feeds the ID-stage control decode. It also absorbs ID stalls with a one-entry skid buffer, applies branch/jump redirects from later stages, and stops fetching on HLT.

## Interface
- `WORD_SIZE`, 16: datapath/address width.
- `RESET_PC`, 16'h0000: PC after reset.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: reset; one clock; reset is asynchronous and active-low.
- `i_mem_read` out 1: instruction read request (registered).
- `i_address` out WORD_SIZE: read address; stable while `i_mem_read`=1.
- `i_data` in WORD_SIZE: read data; valid when `i_ready`=1.
- `i_ready` in 1: memory completes the current request this cycle.
- `id_stall` in 1: hazard unit freezes IF/ID.
- `redirect_valid` in 1: taken branch/jump resolved downstream.
- `redirect_pc` in WORD_SIZE: redirect target.
- `halt` in 1: HLT decoded in ID; fetch stops permanently.
- `if_id_inst` out WORD_SIZE: instruction to ID; `BUBBLE_INST` when invalid.
- `if_id_pc_next` out WORD_SIZE: fetch address + 1, used by JAL/JRL link.
- `if_id_valid` out 1: IF/ID holds a real instruction.
- `fetch_count` out WORD_SIZE: instructions delivered to IF/ID, wraps modulo 2^16.

## Operation
- States:
  - IDLE: no request.
  - REQ: request outstanding.
  - DRAIN: wrong-path request outstanding, its data is discarded.
  - HALTED: terminal.
- Memory handshake:
  - In REQ, `i_mem_read`=1 with `i_address`=pc.
  - A request is never withdrawn; it ends only on `i_ready`=1.
  - Zero-wait memory (ready in the first request cycle) yields 1 instruction/cycle.
- Delivery on `i_ready` in REQ:
  - If IF/ID is free (not stalled), or the skid buffer is empty and IF/ID is being consumed: word goes to IF/ID with `if_id_valid`=1 and `if_id_pc_next`=pc+1.
  - Otherwise the word goes to the skid buffer.
  - pc becomes pc+1, wrapping 16'hFFFF→16'h0000.
- Stall:
  - While `id_stall`=1, IF/ID holds its value.
  - When the stall releases, the skid buffer entry moves to IF/ID before any new memory data.
  - No new request is issued while the buffer is full; the FSM goes to IDLE and returns to REQ when the buffer drains.
- Redirect (priority over stall):
  - IF/ID is flushed: valid=0, inst=`BUBBLE_INST`.
  - The skid buffer is cleared and pc is loaded with `redirect_pc`.
  - REQ without `i_ready` → DRAIN. DRAIN on `i_ready` discards the data → REQ at `redirect_pc`.
  - REQ with `i_ready` in the same cycle: data discarded → REQ at `redirect_pc` next cycle.
- Halt:
  - No further requests are issued.
  - IF/ID is flushed and the skid buffer cleared.
  - If a request is outstanding, it is held until `i_ready`, then discarded; the FSM then enters HALTED.
  - HALTED ignores `redirect_valid` and `id_stall`. Only reset leaves HALTED.
  - `halt` outranks `redirect_valid`.
- `fetch_count` increments on every cycle in which IF/ID loads a valid instruction, whether from memory or from the buffer.

## Timing
- Reset values: state IDLE, pc=`RESET_PC`, `i_mem_read`=0, `i_address`=`RESET_PC`, `if_id_inst`=`BUBBLE_INST`, `if_id_valid`=0, `if_id_pc_next`=0, `fetch_count`=0, buffer empty.
- First clock edge after reset deassertion: IDLE→REQ. Request visible the following cycle.
- Latency: a request accepted (`i_ready`) at edge N is visible in IF/ID after edge N; ID sees it in cycle N+1.
- Redirect sampled at edge N: `i_mem_read` for `redirect_pc` is asserted after edge N, or after the drain completes.
- Reset asserted mid-request:
  - Outputs go to reset values immediately (async).
  - Any pending memory response is the memory's concern; the block samples nothing until the next REQ.

## Structure
- `BUBBLE_INST` (16'hF03F, undefined R-type func, decodes to no control activity) and the state encodings go in the shared `opcodes.v` header next to `WORD_SIZE`.
- One sub-module: `fetch_skid_buffer`, the one-entry inst/pc_next holding register with valid flag, load, unload and clear.

## Test plan
- Reset, then zero-wait memory returning 16'h6001, 16'h6102, 16'h6203 → `if_id_inst` shows them on consecutive cycles; `if_id_pc_next`=1,2,3; `fetch_count`=3.
- Memory with 2-cycle ready → `i_address` is stable across the wait cycles; one instruction per 3 cycles.
- `id_stall` held 3 cycles with zero-wait memory:
  - IF/ID unchanged throughout.
  - Exactly one word is held in the buffer and `i_mem_read` drops.
  - After release, the buffered word appears first and no instruction is lost or duplicated.
- `redirect_valid` with `redirect_pc`=16'h0040 during a waiting request:
  - IF/ID flushes to a bubble.
  - The old request completes and its data is discarded.
  - The next `i_address` is 16'h0040.
- Redirect and stall in the same cycle → flush happens, next fetch is at the target.
- `halt` while a request is outstanding → the request completes and is discarded; `i_mem_read` stays 0 afterwards even with redirects; async reset mid-run returns all outputs to reset values within the same cycle.
